// File: rtl/udp_tx_pkg.sv
// Shared types and constants for the UDP transmit scheduler.
package udp_tx_pkg;

  localparam int UDP_MAX_PAYLOAD = 1472;
  localparam int LEN_W           = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_DRAIN
  } state_e;

  // A zero-length datagram is rejected as well as anything over the limit.
  function automatic logic len_legal(input logic [LEN_W-1:0] len, input int max_len);
    return (len != '0) && ({{(32-LEN_W){1'b0}}, len} <= 32'(max_len));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the slot after the last winner.
// The pointer only moves when the consumer strobes adv_i.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic [N-1:0]  req_i,
  input  logic          adv_i,
  output logic [N-1:0]  gnt_oh_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_vld_o
);

  logic [IW-1:0] ptr_q;

  always_comb begin
    int idx;
    idx       = 0;
    gnt_idx_o = ptr_q;
    gnt_vld_o = 1'b0;
    gnt_oh_o  = '0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr_q) + i) % N;
      if (!gnt_vld_o && req_i[idx]) begin
        gnt_vld_o     = 1'b1;
        gnt_idx_o     = IW'(idx);
        gnt_oh_o[idx] = 1'b1;
      end
    end
  end

  // Reset to the last slot so that slot 0 is searched first.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ptr_q <= IW'(N - 1);
    end else if (adv_i && gnt_vld_o) begin
      ptr_q <= gnt_idx_o;
    end
  end

endmodule

// File: rtl/udp_tx_sched.sv
// Packet-granular round-robin scheduler feeding one UDP frame builder,
// with length/payload consistency enforcement.
//   state    | meaning
//   ST_IDLE  | waiting for any length request
//   ST_LEN   | presenting granted length (or consuming an illegal one)
//   ST_DATA  | passing payload bytes through from the granted source
//   ST_DRAIN | discarding granted source bytes up to its tlast
module udp_tx_sched
  import udp_tx_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int MAX_LEN = UDP_MAX_PAYLOAD,
  parameter int IW      = $clog2(NUM_SRC)
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [NUM_SRC-1:0]       src_length_tvalid_i,
  output logic [NUM_SRC-1:0]       src_length_tready_o,
  input  logic [LEN_W*NUM_SRC-1:0] src_length_tdata_i,
  input  logic [NUM_SRC-1:0]       src_udp_tvalid_i,
  output logic [NUM_SRC-1:0]       src_udp_tready_o,
  input  logic [8*NUM_SRC-1:0]     src_udp_tdata_i,
  input  logic [NUM_SRC-1:0]       src_udp_tlast_i,
  input  logic [NUM_SRC-1:0]       src_udp_tuser_i,
  output logic                     length_tvalid_o,
  input  logic                     length_tready_i,
  output logic [LEN_W-1:0]         length_tdata_o,
  output logic                     udp_tvalid_o,
  input  logic                     udp_tready_i,
  output logic [7:0]               udp_tdata_o,
  output logic                     udp_tlast_o,
  output logic                     udp_tuser_o,
  output logic [IW-1:0]            grant_id_o,
  output logic                     busy_o,
  output logic                     err_pulse_o,
  output logic [31:0]              pkt_count_o,
  output logic [15:0]              err_count_o
);

  state_e           state_q;
  logic [IW-1:0]    grant_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] byte_cnt_q;
  logic [31:0]      pkt_cnt_q;
  logic [15:0]      err_cnt_q;
  logic             err_pulse_q;

  logic [NUM_SRC-1:0] arb_oh;
  logic [IW-1:0]      arb_idx;
  logic               arb_vld;

  logic [LEN_W-1:0] g_len;
  logic             g_len_ok;
  logic             g_lvld, g_uvld, g_last, g_user;
  logic [7:0]       g_data;
  logic             end_c, mismatch, len_hs, u_hs;
  logic             err_evt, pkt_evt;

  rr_arbiter #(.N(NUM_SRC), .IW(IW)) u_arb (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .req_i    (src_length_tvalid_i),
    .adv_i    (state_q == ST_IDLE),
    .gnt_oh_o (arb_oh),
    .gnt_idx_o(arb_idx),
    .gnt_vld_o(arb_vld)
  );

  always_comb begin
    g_len    = src_length_tdata_i[LEN_W*grant_q +: LEN_W];
    g_len_ok = len_legal(g_len, MAX_LEN);
    g_lvld   = src_length_tvalid_i[grant_q];
    g_uvld   = src_udp_tvalid_i[grant_q];
    g_last   = src_udp_tlast_i[grant_q];
    g_user   = src_udp_tuser_i[grant_q];
    g_data   = src_udp_tdata_i[8*grant_q +: 8];
    // len_q is at least 1 whenever DATA is entered, so len_q-1 cannot wrap.
    end_c    = (byte_cnt_q == len_q - LEN_W'(1));
    mismatch = g_last ^ end_c;

    src_length_tready_o = '0;
    src_udp_tready_o    = '0;
    length_tvalid_o     = 1'b0;
    length_tdata_o      = '0;
    udp_tvalid_o        = 1'b0;
    udp_tdata_o         = '0;
    udp_tlast_o         = 1'b0;
    udp_tuser_o         = 1'b0;

    unique case (state_q)
      ST_LEN: begin
        length_tvalid_o              = g_len_ok;
        length_tdata_o               = g_len_ok ? g_len : '0;
        src_length_tready_o[grant_q] = g_len_ok ? length_tready_i : 1'b1;
      end
      ST_DATA: begin
        udp_tvalid_o              = g_uvld;
        udp_tdata_o               = g_data;
        udp_tlast_o               = g_last | end_c;
        udp_tuser_o               = g_user | mismatch;
        src_udp_tready_o[grant_q] = udp_tready_i;
      end
      ST_DRAIN: src_udp_tready_o[grant_q] = 1'b1;
      default: ;
    endcase

    len_hs  = (state_q == ST_LEN) && g_lvld && src_length_tready_o[grant_q];
    u_hs    = (state_q == ST_DATA) && g_uvld && udp_tready_i;
    err_evt = (len_hs && !g_len_ok) ||
              (u_hs && (g_last ? (mismatch || g_user) : end_c));
    pkt_evt = u_hs && g_last && !mismatch && !g_user;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      len_q       <= '0;
      byte_cnt_q  <= '0;
      pkt_cnt_q   <= '0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      err_pulse_q <= err_evt;
      if (err_evt && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
      if (pkt_evt) pkt_cnt_q <= pkt_cnt_q + 32'd1;

      unique case (state_q)
        ST_IDLE: begin
          if (arb_vld) begin
            grant_q <= arb_idx;
            state_q <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (len_hs) begin
            if (g_len_ok) begin
              len_q      <= g_len;
              byte_cnt_q <= '0;
              state_q    <= ST_DATA;
            end else begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DATA: begin
          if (u_hs) begin
            byte_cnt_q <= byte_cnt_q + LEN_W'(1);
            if (g_last)     state_q <= ST_IDLE;
            else if (end_c) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (g_uvld && g_last) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant_id_o  = grant_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign err_pulse_o = err_pulse_q;
  assign pkt_count_o = pkt_cnt_q;
  assign err_count_o = err_cnt_q;

endmodule

// File: tb/tb_udp_tx_sched.sv
// Directed bench for udp_tx_sched with per-source drivers and an output monitor.
module tb_udp_tx_sched;

  localparam int N   = 4;
  localparam int TMO = 100;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [N-1:0]    s_len_v, s_len_r, s_u_v, s_u_r, s_u_last, s_u_user;
  logic [16*N-1:0] s_len_d;
  logic [8*N-1:0]  s_u_d;
  logic            len_v, len_r, u_v, u_r, u_last, u_user, busy, errp;
  logic [15:0]     len_d, errc;
  logic [7:0]      u_d;
  logic [1:0]      gid;
  logic [31:0]     pkt;

  udp_tx_sched #(.NUM_SRC(N), .MAX_LEN(1472)) dut (
    .clk_i              (clk),
    .rstn_i             (rstn),
    .src_length_tvalid_i(s_len_v),
    .src_length_tready_o(s_len_r),
    .src_length_tdata_i (s_len_d),
    .src_udp_tvalid_i   (s_u_v),
    .src_udp_tready_o   (s_u_r),
    .src_udp_tdata_i    (s_u_d),
    .src_udp_tlast_i    (s_u_last),
    .src_udp_tuser_i    (s_u_user),
    .length_tvalid_o    (len_v),
    .length_tready_i    (len_r),
    .length_tdata_o     (len_d),
    .udp_tvalid_o       (u_v),
    .udp_tready_i       (u_r),
    .udp_tdata_o        (u_d),
    .udp_tlast_o        (u_last),
    .udp_tuser_o        (u_user),
    .grant_id_o         (gid),
    .busy_o             (busy),
    .err_pulse_o        (errp),
    .pkt_count_o        (pkt),
    .err_count_o        (errc)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit abort = 1'b0;

  logic [9:0]  out_q[$];
  logic [15:0] lenq[$];
  logic [1:0]  gnt_q[$];
  int nlenv, npulse;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] out_at(input int i);
    return (i < out_q.size()) ? 32'(out_q[i]) : 32'hDEADBEEF;
  endfunction
  function automatic logic [31:0] gnt_at(input int i);
    return (i < gnt_q.size()) ? 32'(gnt_q[i]) : 32'hDEADBEEF;
  endfunction
  function automatic logic [31:0] len_at(input int i);
    return (i < lenq.size()) ? 32'(lenq[i]) : 32'hDEADBEEF;
  endfunction

  // Sampling on the falling edge: inputs and outputs are stable until the next rising edge.
  always @(negedge clk) begin
    if (rstn) begin
      if (u_v && u_r) out_q.push_back({u_user, u_last, u_d});
      if (len_v && len_r) begin
        lenq.push_back(len_d);
        gnt_q.push_back(gid);
      end
      if (len_v) nlenv++;
      if (errp) npulse++;
    end
  end

  task automatic wait_hs(input int s, input bit is_len, input string tag);
    int t;
    t = 0;
    while (!abort) begin
      @(negedge clk);
      if (is_len ? s_len_r[s] : s_u_r[s]) break;
      t++;
      if (t > TMO) begin
        n_vec++;
        n_bad++;
        $display("FAIL %s: no handshake from src %0d within %0d cycles", tag, s, TMO);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_len(input int s, input int l);
    s_len_d[16*s +: 16] = 16'(l);
    s_len_v[s] = 1'b1;
    wait_hs(s, 1'b1, "len_tmo");
    s_len_v[s] = 1'b0;
  endtask

  task automatic send_bytes(input int s, input int n, input int first, input int step);
    for (int k = 0; k < n && !abort; k++) begin
      s_u_d[8*s +: 8] = 8'(first + k*step);
      s_u_last[s]     = (k == n-1);
      s_u_user[s]     = 1'b0;
      s_u_v[s]        = 1'b1;
      wait_hs(s, 1'b0, "byte_tmo");
    end
    s_u_v[s]    = 1'b0;
    s_u_last[s] = 1'b0;
  endtask

  task automatic send_pkt(input int s, input int l, input int n, input int first);
    send_len(s, l);
    if (!abort) send_bytes(s, n, first, 1);
  endtask

  task automatic clear_mon();
    @(posedge clk);
    #1;
    out_q.delete();
    lenq.delete();
    gnt_q.delete();
    nlenv  = 0;
    npulse = 0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    s_len_v = '0; s_len_d = '0; s_u_v = '0; s_u_d = '0; s_u_last = '0; s_u_user = '0;
    len_r = 1'b1;
    u_r   = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_lenv", len_v, 0);
    chk("rst_uv", u_v, 0);
    chk("rst_slr", s_len_r, 0);
    chk("rst_sur", s_u_r, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gid", gid, 0);
    chk("rst_pkt", pkt, 0);
    chk("rst_err", errc, 0);
    chk("rst_errp", errp, 0);
    rstn = 1'b1;

    // single packet, one-cycle decision latency
    clear_mon();
    s_len_d[15:0] = 16'd4;
    s_len_v[0]    = 1'b1;
    @(negedge clk);
    chk("t1_lenv_early", len_v, 0);
    @(negedge clk);
    chk("t1_lenv", len_v, 1);
    chk("t1_lend", len_d, 4);
    chk("t1_gid", gid, 0);
    chk("t1_slr0", s_len_r, 4'b0001);
    @(posedge clk);
    #1 s_len_v[0] = 1'b0;
    send_bytes(0, 4, 8'h11, 8'h11);
    settle();
    chk("t1_nout", out_q.size(), 4);
    chk("t1_b0", out_at(0), 10'h011);
    chk("t1_b1", out_at(1), 10'h022);
    chk("t1_b2", out_at(2), 10'h033);
    chk("t1_b3", out_at(3), 10'h144);
    chk("t1_pkt", pkt, 1);
    chk("t1_err", errc, 0);

    // simultaneous requests after reset: order 0,1,2,3
    do_reset();
    clear_mon();
    fork
      send_pkt(0, 2, 2, 8'hA0);
      send_pkt(1, 2, 2, 8'hB0);
      send_pkt(2, 2, 2, 8'hC0);
      send_pkt(3, 2, 2, 8'hD0);
    join
    settle();
    for (int i = 0; i < 4; i++) chk($sformatf("t2_gnt%0d", i), gnt_at(i), i);
    chk("t2_nout", out_q.size(), 8);
    chk("t2_pkt", pkt, 4);
    chk("t2_err", errc, 0);

    // lone requester re-granted, length 1
    clear_mon();
    send_pkt(2, 1, 1, 8'h7E);
    send_pkt(2, 1, 1, 8'h7F);
    settle();
    chk("t2b_gnt0", gnt_at(0), 2);
    chk("t2b_gnt1", gnt_at(1), 2);
    chk("t2b_b1", out_at(1), 10'h17F);
    chk("t2b_pkt", pkt, 6);

    // early tlast
    clear_mon();
    send_pkt(1, 3, 2, 8'h31);
    settle();
    chk("t3_nout", out_q.size(), 2);
    chk("t3_b0", out_at(0), 10'h031);
    chk("t3_b1", out_at(1), 10'h332);
    chk("t3_pulses", npulse, 1);
    chk("t3_err", errc, 1);
    chk("t3_pkt", pkt, 6);

    // overlong payload drained
    clear_mon();
    send_pkt(2, 2, 5, 8'h41);
    settle();
    chk("t4_nout", out_q.size(), 2);
    chk("t4_b0", out_at(0), 10'h041);
    chk("t4_b1", out_at(1), 10'h342);
    chk("t4_pulses", npulse, 1);
    chk("t4_err", errc, 2);
    chk("t4_busy", busy, 0);

    // illegal lengths 0, 1500, 1473
    clear_mon();
    send_pkt(3, 0, 3, 8'h51);
    send_pkt(3, 1500, 2, 8'h55);
    send_pkt(3, 1473, 1, 8'h58);
    settle();
    chk("t5_lenv", nlenv, 0);
    chk("t5_nout", out_q.size(), 0);
    chk("t5_pulses", npulse, 3);
    chk("t5_err", errc, 5);
    chk("t5_pkt", pkt, 6);

    // largest legal length
    clear_mon();
    send_pkt(0, 1472, 1472, 0);
    settle();
    chk("t5b_len", len_at(0), 1472);
    chk("t5b_nout", out_q.size(), 1472);
    chk("t5b_first", out_at(0), 10'h000);
    chk("t5b_last", out_at(1471), 10'h1BF);
    chk("t5b_pkt", pkt, 7);
    chk("t5b_err", errc, 5);

    // reset mid-DATA with toggling sink ready
    clear_mon();
    fork
      send_pkt(0, 8, 8, 8'h61);
      begin
        for (int i = 0; i < 6; i++) begin
          @(posedge clk);
          #1 u_r = ~u_r;
        end
        @(posedge clk);
        #2;
        chk("t6_busy_pre", busy, 1);
        rstn = 1'b0;
        #1;
        chk("t6_lenv", len_v, 0);
        chk("t6_uv", u_v, 0);
        chk("t6_slr", s_len_r, 0);
        chk("t6_sur", s_u_r, 0);
        chk("t6_busy", busy, 0);
        chk("t6_pkt", pkt, 0);
        chk("t6_err", errc, 0);
        chk("t6_gid", gid, 0);
        abort = 1'b1;
      end
    join
    u_r = 1'b1;
    s_len_v = '0; s_u_v = '0; s_u_last = '0;
    abort = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    clear_mon();
    fork
      send_pkt(1, 1, 1, 8'h91);
      send_pkt(0, 1, 1, 8'h90);
    join
    settle();
    chk("t6_gnt0", gnt_at(0), 0);
    chk("t6_gnt1", gnt_at(1), 1);
    chk("t6_pkt_after", pkt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/udp_tx_sched.md
Name: udp_tx_sched

Overview:
- Round-robin packet scheduler that shares one UDP transmit path (length channel plus payload byte stream into the ARP/UDP frame builder) between NUM_SRC independent payload sources.
- Grants at packet granularity and forwards each source's length word, then its payload bytes.
- Enforces length/payload consistency so the builder never emits an IP/UDP header whose length disagrees with the payload.
- Sits between application-side payload FIFOs and the frame builder.

Parameters:
NUM_SRC, 4, number of requesting sources (2..8)
MAX_LEN, 1472, largest legal UDP payload in bytes; lengths 0 or >MAX_LEN are rejected

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
src_length_tvalid  in  NUM_SRC  per-source length valid
src_length_tready  out  NUM_SRC  per-source length ready
src_length_tdata  in  16*NUM_SRC  per-source payload length, source i at [16i+15:16i]
src_udp_tvalid  in  NUM_SRC  per-source payload valid
src_udp_tready  out  NUM_SRC  per-source payload ready
src_udp_tdata  in  8*NUM_SRC  per-source payload byte
src_udp_tlast  in  NUM_SRC  per-source last byte
src_udp_tuser  in  NUM_SRC  per-source bad-frame mark
length_tvalid  out  1  length to frame builder
length_tready  in  1
length_tdata  out  16
udp_tvalid  out  1  payload to frame builder
udp_tready  in  1
udp_tdata  out  8
udp_tlast  out  1
udp_tuser  out  1  set = builder/MAC must discard frame
grant_id  out  $clog2(NUM_SRC)  currently/last granted source
busy  out  1  state != IDLE
err_pulse  out  1  one-cycle pulse per rejected or mismatched packet
pkt_count  out  32  packets forwarded with tuser=0, wraps
err_count  out  16  errors, saturates at 16'hFFFF

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE; all tvalid/tready outputs 0; err_pulse=0; counters 0.
  - rr pointer = NUM_SRC-1, so source 0 wins first; grant_id=0.
- IDLE:
  - If any src_length_tvalid, pick the first requester at or after (pointer+1) mod NUM_SRC, register it as grant_id, update pointer, and go to LEN.
  - One-cycle decision latency: length_tvalid rises the cycle after the request is seen.
- LEN:
  - Legal length (1..MAX_LEN): length_tvalid=1, length_tdata=granted length, src_length_tready[g]=length_tready. On handshake, latch len, byte_cnt=0, go to DATA.
  - Illegal length: length_tvalid=0, src_length_tready[g]=1 for one cycle, err_pulse, err_count++, go to DRAIN.
- DATA (combinational pass-through from granted source, zero latency):
  - udp_tvalid = src_udp_tvalid[g]; src_udp_tready[g] = udp_tready; udp_tdata = src byte.
  - end = (byte_cnt == len-1); udp_tlast = src_tlast | end; mismatch = src_tlast XOR end; udp_tuser = src_tuser | mismatch.
  - On each handshake byte_cnt++.
  - On src_tlast: go to IDLE; if mismatch or src_tuser, err_pulse and err_count++ (early tlast counts as error); otherwise pkt_count++.
  - On end without src_tlast: go to DRAIN, err_pulse, err_count++.
- DRAIN:
  - src_udp_tready[g]=1; udp_tvalid=0.
  - Discard bytes until a src_udp_tvalid & src_udp_tlast handshake, then go to IDLE.
- Non-granted sources: tready 0 in every state.
- Simultaneous requests: exactly one grant, rotating fairly. A source that is the only requester is re-granted back-to-back.
- Widths: byte_cnt 16 bits; len-1 is computed only for len >= 1.
- Reset mid-packet: outputs drop immediately. The frame builder shares rstn and also aborts. No partial state survives.
- tvalid outputs never depend combinationally on the corresponding tready.

Decomposition:
- Package udp_tx_pkg holds:
  - state enum (IDLE, LEN, DATA, DRAIN);
  - UDP_MAX_PAYLOAD = 1472;
  - length width constant 16.
- One sub-module: rr_arbiter (request vector in, one-hot/index grant out, registered pointer, advance strobe). Reusable elsewhere in the stack.

Test Plan:
- Src0 only, length 4, bytes 11 22 33 44 with tlast on 44 -> length_tdata=4 one cycle after request; 4 bytes out, tlast on 44, tuser=0; pkt_count=1.
- Src0–3 all request at once, each length 2 -> grant order 0,1,2,3; next round from src1 onward is 0 again only after 3; pkt_count=4.
- Src1 length 3 but tlast on byte 2 -> tlast on byte 2, udp_tuser=1; err_pulse once; err_count=1; pkt_count unchanged.
- Src2 length 2, source sends 5 bytes -> out tlast+tuser on byte 2; bytes 3–5 drained (src tready=1, udp_tvalid=0); IDLE after 5th byte.
- Src3 length 0 and a separate length 1500 -> no length_tvalid; payload drained; err_count=2.
- rstn low mid-DATA with udp_tready toggling -> all valids/readies 0 asynchronously; after release, src0 granted first.
